key_tone: RTL and testbench
===========================

# key_tone

Square-wave tone generator for the 24-key keyboard. It consumes the `key`/`press` pair produced by the last-pressed-key encoder and drives a single-bit speaker pin at the frequency of the selected note: key 0 = C4 through key 23 = B5, equal temperament. Tone start, stop and note changes take effect only at half-period boundaries, so no runt pulses reach the speaker.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency; used to compute the half-period table at elaboration.
- `RELEASE_MS`, default 200: release hold time in ms. Used only with `KEY_TONE_RELEASE_EN`.
- `clk` in, 1 bit: system clock; all logic on the rising edge.
- `rst_n` in, 1 bit: asynchronous reset, active-low.
- `key` in, 5 bits: note index, synchronous to `clk`. Values 24..31 are invalid.
- `press` in, 1 bit: key held, synchronous to `clk`.
- `spk` out, 1 bit: square-wave speaker drive.
- `active` out, 1 bit: high while a tone is sounding, in PLAY or RELEASE.
- `note` out, 5 bits: index currently being generated; holds its last value when idle.

## Operation
- Half-period table: `HP[k] = floor(CLK_HZ*1000 / (2*F_mHz[k]))`. Counter width is 24 bits, enough for CLK_HZ up to 100 MHz.
- States:
  - IDLE: `spk=0`, `active=0`.
  - PLAY: counter counts down from `HP[note]-1`; at 0 it reloads and toggles `spk`.
  - RELEASE: same as PLAY, but `press` is low and a release timer is running.
- IDLE -> PLAY: `press=1` and `key<24`. Same edge: latch `note<=key`, `spk<=1`, load counter.
- `press=1` with `key>=24` is ignored; the block stays in, or behaves as, `press=0`.
- Note change in PLAY: `key` differs from `note` while `press=1`. Latch the new key as pending; apply it (`note` and reload value) at the next toggle. Only the most recent pending key is kept.
- PLAY, `press` falls:
  - Without the macro: enter STOPPING behaviour. At the next toggle that drives `spk` to 0, go to IDLE.
  - With the macro: go to RELEASE.
- RELEASE:
  - Timer counts `CLK_HZ/1000*RELEASE_MS` cycles.
  - `press=1` with a valid key returns to PLAY, with the note-change rule applied.
  - Timer expiry -> stop at the next 1->0 toggle, then IDLE.
- Reset mid-tone: immediately `spk=0`, `active=0`, `note=0`, state IDLE, counters 0.
- `press` must be low-then-high to restart only from IDLE. A held `press` in IDLE after reset starts a tone on the first clock after `rst_n` deasserts.

## Timing
- Reset values: `spk=0`, `active=0`, `note=0`.
- Start latency: one cycle. `press` is sampled high at edge N; `spk`, `active` and `note` are valid after edge N.
- Each `spk` level lasts exactly `HP[note]` cycles; the period is `2*HP[note]`.
- Note change takes effect at the first toggle after detection. The latency is at most `HP[old]` cycles.
- Stop: `spk` always ends low. `active` drops on the same edge that `spk` goes 0 for the final time.
- Simultaneous events:
  - `press` fall and a toggle on the same edge: the toggle happens with the old rules; the stop condition is evaluated from the next edge.
  - Key change and a toggle on the same edge: the new key applies at that toggle.

## Configuration
- `KEY_TONE_RELEASE_EN` defined: RELEASE state and release timer are compiled in; `RELEASE_MS` is honoured.
- `KEY_TONE_RELEASE_EN` undefined: no release timer. Release of `press` stops the tone at the next 1->0 toggle.

## Structure
- Package `key_tone_pkg` holds:
  - the `F_mHz[0:23]` note frequency constants (261626 … 987767);
  - the state enum;
  - the `NUM_KEYS=24` constant;
  - the half-period compute function.
- Sub-module `tone_div`: loadable down-counter with toggle output and a `boundary` strobe. `key_tone` holds the FSM, pending-note register and release timer.

## Test plan
- `CLK_HZ=1_000_000`, `press=1`, `key=9` -> `spk` high the next cycle; levels of 1136 cycles each; `active=1`, `note=9`.
- `key=0` playing, switch to `key=23` mid-half-period -> current level completes at 1911 cycles, then levels of 506 cycles; no level shorter than 506.
- `press=0` while `spk=1`, macro off -> `spk` falls at the scheduled toggle, stays 0; `active` falls on that same edge.
- Macro on, `RELEASE_MS=2`, `press` drops -> tone continues about 2000 cycles, then ends low. A re-press within 1000 cycles keeps `active` high with no gap.
- `press=1`, `key=27` -> `spk=0`, `active=0` indefinitely.
- Assert `rst_n=0` mid-high-level -> `spk`, `active` and `note` are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/key_tone_pkg.sv
// Shared constants for the 24-key tone generator: note frequencies, FSM states
// and the elaboration-time half-period calculation.
package key_tone_pkg;

   localparam int NUM_KEYS = 24;

   // Equal-temperament frequencies in millihertz, C4 (key 0) through B5 (key 23).
   localparam int unsigned F_mHz [NUM_KEYS] = '{
      261626, 277183, 293665, 311127, 329628, 349228,
      369994, 391995, 415305, 440000, 466164, 493883,
      523251, 554365, 587330, 622254, 659255, 698456,
      739989, 783991, 830609, 880000, 932328, 987767
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_STOP,
      ST_REL
   } tone_state_e;

   // Cycles per speaker level for note k; only ever called with constant arguments.
   function automatic logic [23:0] half_period(input longint clk_hz, input int k);
      longint hp;
      hp = (clk_hz * 64'd1000) / (64'd2 * longint'(F_mHz[k]));
      return 24'(hp);
   endfunction

endpackage

// File: rtl/key_tone_div.sv
// Loadable half-period down-counter owning the speaker flop; boundary marks the
// last cycle of a level, where the level flips and the counter reloads.
module tone_div
   import key_tone_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt,
   input  logic        en,
   input  logic [23:0] reload,
   output logic        out,
   output logic        boundary
);

   logic [23:0] cnt;

   assign boundary = en && (cnt == 24'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 24'd0;
         out <= 1'b0;
      end else if (halt) begin
         cnt <= 24'd0;
         out <= 1'b0;
      end else if (start) begin
         cnt <= reload;
         out <= 1'b1;
      end else if (boundary) begin
         cnt <= reload;
         out <= ~out;
      end else if (en) begin
         cnt <= cnt - 24'd1;
      end
   end

endmodule

// File: rtl/key_tone.sv
// Square-wave tone generator for the 24-key keyboard. Define KEY_TONE_RELEASE_EN
// to compile in the release hold (RELEASE state and timer).
module key_tone
   import key_tone_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int RELEASE_MS = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] key,
   input  logic       press,
   output logic       spk,
   output logic       active,
   output logic [4:0] note
);

   tone_state_e state;
   logic [4:0]  pend;
   logic [4:0]  next_note;
   logic        valid;
   logic        start;
   logic        halt;
   logic        run;
   logic        boundary;
   logic [23:0] reload;
   logic [23:0] hp_m1 [NUM_KEYS];

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_hp
      assign hp_m1[k] = half_period(longint'(CLK_HZ), k) - 24'd1;
   end

`ifdef KEY_TONE_RELEASE_EN
   localparam logic [31:0] REL_CYC = 32'(CLK_HZ / 1000 * RELEASE_MS);
   logic [31:0] timer;
`endif

   // An out-of-range key is treated exactly like a released key.
   assign valid     = press && (key < 5'(NUM_KEYS));
   assign next_note = (valid && state != ST_STOP) ? key : pend;
   assign start     = (state == ST_IDLE) && valid;
   assign halt      = (state == ST_STOP) && boundary && spk;
   assign run       = (state != ST_IDLE);
   assign reload    = hp_m1[next_note];

   tone_div u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .halt     (halt),
      .en       (run),
      .reload   (reload),
      .out      (spk),
      .boundary (boundary)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         note   <= 5'd0;
         pend   <= 5'd0;
         active <= 1'b0;
`ifdef KEY_TONE_RELEASE_EN
         timer  <= 32'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid) begin
                  note   <= key;
                  pend   <= key;
                  active <= 1'b1;
                  state  <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               // Pending note follows the key; it only reaches note at a level flip.
               pend <= next_note;
               if (boundary) note <= next_note;
               if (!valid) begin
`ifdef KEY_TONE_RELEASE_EN
                  state <= ST_REL;
                  timer <= REL_CYC - 32'd1;
`else
                  state <= ST_STOP;
`endif
               end
            end
`ifdef KEY_TONE_RELEASE_EN
            ST_REL: begin
               pend <= next_note;
               if (boundary) note <= next_note;
               if (valid)                 state <= ST_PLAY;
               else if (timer == 32'd0)   state <= ST_STOP;
               else                       timer <= timer - 32'd1;
            end
`endif
            ST_STOP: begin
               // Only a 1->0 flip may end the tone, so spk always finishes low.
               if (boundary && spk) begin
                  state  <= ST_IDLE;
                  active <= 1'b0;
               end else if (boundary) begin
                  note <= next_note;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_tone.sv
// Bench for key_tone at CLK_HZ=1 MHz: directed note/stop/reset steps plus random
// press/key segments, every cycle compared with a level-timing model.
module tb_key_tone;

   localparam int CLK   = 1_000_000;
   localparam int REL_N = CLK / 1000 * 2;
   localparam int S_IDLE = 0, S_PLAY = 1, S_STOP = 2, S_REL = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] key;
   logic       press;
   logic       spk;
   logic       active;
   logic [4:0] note;

   int total = 0;
   int bad   = 0;

   int unsigned f_tab [24] = '{
      261626, 277183, 293665, 311127, 329628, 349228,
      369994, 391995, 415305, 440000, 466164, 493883,
      523251, 554365, 587330, 622254, 659255, 698456,
      739989, 783991, 830609, 880000, 932328, 987767
   };

   // model: current mode, level, note, pending note, cycles left in level, release cycles left
   int m_st, m_spk, m_note, m_pend, m_left, m_rel;

   always #5 clk = ~clk;

   key_tone #(.CLK_HZ(CLK), .RELEASE_MS(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key    (key),
      .press  (press),
      .spk    (spk),
      .active (active),
      .note   (note)
   );

   function automatic int hp_ref(input int k);
      return int'((longint'(CLK) * 1000) / (2 * longint'(f_tab[k])));
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_spk = 0; m_note = 0; m_pend = 0; m_left = 0; m_rel = 0;
   endtask

   task automatic model_step();
      bit v;
      int nn;
      if (!rst_n) begin
         model_reset();
         return;
      end
      v = press && (key < 5'd24);
      if (m_st == S_IDLE) begin
         if (v) begin
            m_st = S_PLAY; m_spk = 1; m_note = int'(key); m_pend = int'(key);
            m_left = hp_ref(int'(key));
         end
         return;
      end
      if (m_left == 1) begin
         if (m_st == S_STOP && m_spk == 1) begin
            m_spk = 0; m_st = S_IDLE;
            return;
         end
         nn = (v && m_st != S_STOP) ? int'(key) : m_pend;
         m_note = nn; m_pend = nn; m_spk = 1 - m_spk; m_left = hp_ref(nn);
      end else begin
         m_left--;
         if (v && m_st != S_STOP) m_pend = int'(key);
      end
      if (m_st == S_PLAY && !v) begin
`ifdef KEY_TONE_RELEASE_EN
         m_st = S_REL; m_rel = REL_N;
`else
         m_st = S_STOP;
`endif
      end else if (m_st == S_REL) begin
         if (v) m_st = S_PLAY;
         else begin
            m_rel--;
            if (m_rel == 0) m_st = S_STOP;
         end
      end
   endtask

   // One clock: model advances on the rising edge, DUT compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("spk", int'(spk), m_spk);
      chk("active", int'(active), int'(m_st != S_IDLE));
      chk("note", int'(note), m_note);
   endtask

   // Length of the level spk is in now (first cycle already seen); optionally
   // changes key/press after cycle 'at' of that level.
   task automatic run_level(output int n, input int at, input logic [4:0] k2, input logic p2);
      logic lvl;
      bit   done;
      lvl = spk; n = 1; done = 0;
      while (!done) begin
         if (n == at) begin key = k2; press = p2; end
         tick();
         if (spk !== lvl || n >= 5000) done = 1;
         else n++;
      end
      chk("level_bounded", int'(n < 5000), 1);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (active && c < 10000) begin tick(); c++; end
      chk("idle_reached", int'(active), 0);
   endtask

   initial begin
      int n, c;
      rst_n = 1'b0; press = 1'b0; key = 5'd0;
      model_reset();
      repeat (3) tick();
      chk("rst_spk", int'(spk), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_note", int'(note), 0);
      rst_n = 1'b1;
      tick();

      // start on key 9: one-cycle latency, 1136-cycle levels
      press = 1'b1; key = 5'd9;
      tick();
      chk("start_spk", int'(spk), 1);
      chk("start_active", int'(active), 1);
      chk("start_note", int'(note), 9);
      run_level(n, -1, 5'd0, 1'b0); chk("a4_high", n, 1136);
      run_level(n, -1, 5'd0, 1'b0); chk("a4_low", n, 1136);

      // change to key 0 mid-level, then to key 23 mid-level
      run_level(n, 10, 5'd0, 1'b1);  chk("a4_level_before_change", n, 1136);
      chk("note_c4", int'(note), 0);
      run_level(n, -1, 5'd0, 1'b1);  chk("c4_low", n, 1911);
      run_level(n, 500, 5'd23, 1'b1); chk("c4_completes", n, 1911);
      chk("note_b5", int'(note), 23);
      run_level(n, -1, 5'd0, 1'b1);  chk("b5_level1", n, 506);
      run_level(n, -1, 5'd0, 1'b1);  chk("b5_level2", n, 506);
      run_level(n, -1, 5'd0, 1'b1);  chk("b5_level3", n, 506);

`ifdef KEY_TONE_RELEASE_EN
      // release holds the tone; a re-press within the window keeps it going
      run_level(n, 100, 5'd23, 1'b0); chk("rel_level_kept", n, 506);
      repeat (800) tick();
      chk("rel_still_active", int'(active), 1);
      press = 1'b1;
      repeat (300) tick();
      chk("repress_active", int'(active), 1);
      press = 1'b0;
      c = 0;
      while (active && c < 6000) begin tick(); c++; end
      chk("rel_len_window", int'(c >= REL_N - 1 && c <= REL_N + 2 * 506), 1);
      chk("rel_end_low", int'(spk), 0);
`else
      // press drops while high: the high level completes, then silence
      run_level(n, 100, 5'd23, 1'b0); chk("stop_high_len", n, 506);
      chk("stop_spk_low", int'(spk), 0);
      chk("stop_active_same_edge", int'(active), 0);
      repeat (1200) tick();
      chk("stop_stays_low", int'(spk), 0);
`endif
      wait_idle();

      // invalid key while pressed is silence
      press = 1'b1; key = 5'd27;
      repeat (3000) tick();
      chk("bad_key_spk", int'(spk), 0);
      chk("bad_key_active", int'(active), 0);

      // random press/key segments
      for (int s = 0; s < 12; s++) begin
         press = ($urandom_range(0, 3) != 0);
         key = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31))
                                           : 5'($urandom_range(0, 23));
         repeat ($urandom_range(300, 2500)) tick();
      end

      // asynchronous reset in the middle of a high level
      press = 1'b0;
      wait_idle();
      press = 1'b1; key = 5'd5;
      tick();
      repeat (50) tick();
      chk("pre_reset_high", int'(spk), 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_spk", int'(spk), 0);
      chk("async_rst_active", int'(active), 0);
      chk("async_rst_note", int'(note), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("held_press_start_spk", int'(spk), 1);
      chk("held_press_start_note", int'(note), 5);
      run_level(n, -1, 5'd5, 1'b1); chk("f4_high", n, hp_ref(5));
      run_level(n, -1, 5'd5, 1'b1); chk("f4_low", n, hp_ref(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
